// File: rtl/conv_enc_frame_ctrl.sv
// conv_enc_frame_ctrl
// Frame sequencer for a convolutional encoder running in encode mode. It
// latches the frame configuration and pulls information bits over a
// valid/ready handshake. Each accepted bit, and then each of K-1 zero tail
// bits, steps the encoder once. Every encoded symbol is delivered through a
// one-entry output register that honours sink backpressure.
//
// Ports
//   clk, rst             clock, asynchronous active-low reset
//   i_start              frame request (sampled in IDLE only)
//   i_frame_len          number of information bits in the frame
//   i_constraint_len     K (3..MAX_K)
//   i_code_rate          n (2..MAX_R)
//   i_gen_poly           generator polynomials, bit k taps input k steps back
//   i_bit/i_bit_valid    information bit source
//   o_bit_ready          bit consumed this cycle
//   o_en_ce              encoder step enable
//   o_mode_sel           encoder mode select
//   o_encoder_bit        bit presented to the encoder
//   o_gen_poly           latched, masked polynomials for the encoder
//   i_encoder_data       encoder combinational output
//   o_sym_data/valid     encoded symbol output register
//   i_sym_ready          sink accepts symbol
//   o_busy               not IDLE
//   o_done               one-cycle pulse when the frame is complete
//   o_err                one-cycle pulse on an illegal configuration
//
// state  | meaning
// -------+----------------------------------------------------
// IDLE   | waiting for i_start, configuration checked here
// DATA   | stepping the encoder with information bits
// TAIL   | stepping the encoder with K-1 zero bits
// DRAIN  | waiting for the last symbol to leave the register

module conv_enc_frame_ctrl #(
    parameter int   MAX_K       = 9,
    parameter int   MAX_R       = 3,
    parameter int   LEN_W       = 16,
    parameter logic ENCODE_MODE = 1'b1,
    parameter logic DECODE_MODE = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic [LEN_W-1:0]              i_frame_len,
    input  logic [3:0]                    i_constraint_len,
    input  logic [1:0]                    i_code_rate,
    input  logic [MAX_R-1:0][MAX_K-1:0]   i_gen_poly,
    input  logic                          i_bit,
    input  logic                          i_bit_valid,
    output logic                          o_bit_ready,
    output logic                          o_en_ce,
    output logic                          o_mode_sel,
    output logic                          o_encoder_bit,
    output logic [MAX_R-1:0][MAX_K-1:0]   o_gen_poly,
    input  logic [MAX_R-1:0]              i_encoder_data,
    output logic [MAX_R-1:0]              o_sym_data,
    output logic                          o_sym_valid,
    input  logic                          i_sym_ready,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DATA  = 2'd1;
    localparam logic [1:0] S_TAIL  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]                  state_q,    state_d;
    logic [1:0]                  rate_q,     rate_d;
    logic [MAX_R-1:0][MAX_K-1:0] poly_q,     poly_d;
    logic [LEN_W-1:0]            bit_cnt_q,  bit_cnt_d;
    logic [3:0]                  tail_cnt_q, tail_cnt_d;
    logic [MAX_R-1:0]            sym_data_q, sym_data_d;
    logic                        sym_valid_q, sym_valid_d;
    logic                        done_q,     done_d;
    logic                        err_q,      err_d;

    logic                        src_avail;
    logic                        fire;
    logic                        cfg_legal;
    logic [MAX_R-1:0][MAX_K-1:0] poly_masked;
    logic [MAX_R-1:0]            sym_masked;

    // The register only frees up for a new symbol when it is empty or being
    // drained in the same cycle, so a stalled sink also stalls the encoder.
    always_comb begin
        src_avail = 1'b0;
        case (state_q)
            S_DATA:  src_avail = i_bit_valid;
            S_TAIL:  src_avail = 1'b1;
            default: src_avail = 1'b0;
        endcase
        fire = src_avail && (!sym_valid_q || i_sym_ready);
    end

    assign cfg_legal = (i_constraint_len >= 4'd3) && (int'(i_constraint_len) <= MAX_K) &&
                       (i_code_rate >= 2'd2) && (int'(i_code_rate) <= MAX_R);

    // Taps at or above K and polynomials at or above n are cleared so the
    // encoder never sees stale history or an unused output branch.
    always_comb begin
        poly_masked = '0;
        for (int r = 0; r < MAX_R; r++) begin
            for (int b = 0; b < MAX_K; b++) begin
                poly_masked[r][b] = i_gen_poly[r][b] &&
                                    (b < int'(i_constraint_len)) &&
                                    (r < int'(i_code_rate));
            end
        end
    end

    always_comb begin
        sym_masked = '0;
        for (int r = 0; r < MAX_R; r++) begin
            sym_masked[r] = i_encoder_data[r] && (r < int'(rate_q));
        end
    end

    always_comb begin
        state_d     = state_q;
        rate_d      = rate_q;
        poly_d      = poly_q;
        bit_cnt_d   = bit_cnt_q;
        tail_cnt_d  = tail_cnt_q;
        sym_data_d  = sym_data_q;
        sym_valid_d = sym_valid_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        if (fire) begin
            sym_data_d  = sym_masked;
            sym_valid_d = 1'b1;
        end else if (i_sym_ready) begin
            sym_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if (cfg_legal) begin
                        rate_d     = i_code_rate;
                        poly_d     = poly_masked;
                        bit_cnt_d  = i_frame_len;
                        tail_cnt_d = i_constraint_len - 4'd1;
                        state_d    = (i_frame_len == '0) ? S_TAIL : S_DATA;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (fire) begin
                    bit_cnt_d = bit_cnt_q - LEN_W'(1);
                    if (bit_cnt_q == LEN_W'(1)) begin
                        state_d = S_TAIL;
                    end
                end
            end
            S_TAIL: begin
                if (fire) begin
                    tail_cnt_d = tail_cnt_q - 4'd1;
                    if (tail_cnt_q == 4'd1) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!sym_valid_q || i_sym_ready) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rate_q      <= '0;
            poly_q      <= '0;
            bit_cnt_q   <= '0;
            tail_cnt_q  <= '0;
            sym_data_q  <= '0;
            sym_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rate_q      <= rate_d;
            poly_q      <= poly_d;
            bit_cnt_q   <= bit_cnt_d;
            tail_cnt_q  <= tail_cnt_d;
            sym_data_q  <= sym_data_d;
            sym_valid_q <= sym_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign o_en_ce       = fire;
    assign o_bit_ready   = fire && (state_q == S_DATA);
    assign o_encoder_bit = (state_q == S_DATA) ? i_bit : 1'b0;
    assign o_mode_sel    = (state_q == S_IDLE) ? DECODE_MODE : ENCODE_MODE;
    assign o_gen_poly    = poly_q;
    assign o_sym_data    = sym_data_q;
    assign o_sym_valid   = sym_valid_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_done        = done_q;
    assign o_err         = err_q;

endmodule
